sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
//
// PURPOSE
// - Sits directly downstream of the per-sprite line renderers (one per sprite); consumes their
//   pixel index and drawing strobes and feeds the VGA output register.
// - Per pixel: picks the highest-priority opaque sprite, falls back to the background index,
//   and maps the result through a 16-entry RGB palette.
// - Delays hsync/vsync/de so they stay aligned with the RGB output.
// - Palette writes are double-buffered and committed only at the start of vertical sync,
//   so no frame tears.
//
// PARAMETERS
// - NUM_SPR    4   number of sprite inputs; index 0 has the highest priority
// - COLR_BITS  4   palette index width; palette depth is 2**COLR_BITS
// - CHAN_BITS  8   bits per R/G/B channel
// - TRANSP     0   colour index treated as transparent on sprite inputs
//
// PORTS
// - clk          in   1                    system clock
// - rst_n        in   1                    synchronous active-low reset
// - spr_pix      in   NUM_SPR*COLR_BITS    sprite colour indices; sprite i at [i*COLR_BITS +: COLR_BITS]
// - spr_drawing  in   NUM_SPR              per-sprite drawing strobe; leads spr_pix by one cycle
// - bg_idx       in   COLR_BITS            background colour index for the current pixel
// - hsync_in     in   1                    horizontal sync, aligned with spr_drawing
// - vsync_in     in   1                    vertical sync, aligned with spr_drawing; active high
// - de_in        in   1                    display enable, aligned with spr_drawing
// - pal_we       in   1                    shadow palette write strobe
// - pal_addr     in   COLR_BITS            shadow palette write address
// - pal_data     in   3*CHAN_BITS          {R,G,B} write data
// - pal_commit   in   1                    one-cycle pulse: request shadow->active copy at next vsync
// - pal_pending  out  1                    commit requested, not yet applied
// - rgb          out  3*CHAN_BITS          {R,G,B} output; zero when de_out=0
// - hsync_out    out  1                    hsync_in delayed by LAT
// - vsync_out    out  1                    vsync_in delayed by LAT
// - de_out       out  1                    de_in delayed by LAT
//
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): rgb, hsync_out, vsync_out, de_out, pal_pending and all
//   pipeline registers go to 0. Active and shadow palettes clear to 0. Reset mid-frame takes
//   effect on the next edge; no partial output survives.
// - Pipeline, LAT = 3 cycles from *_in/spr_drawing to outputs:
//   - S0: register spr_drawing and the three syncs. This aligns drawing with spr_pix.
//   - S1: select. Sprite i is opaque when drawing_d[i] && spr_pix[i] != TRANSP. sel_idx is the
//     pix of the lowest opaque i; if no sprite is opaque, sel_idx = bg_idx delayed one cycle.
//     bg_idx is NOT subject to TRANSP.
//   - S2: active palette read at sel_idx, registered.
//   - S3: rgb <= de ? pal_q : 0; syncs emitted.
// - Palette write: pal_we writes pal_data to shadow[pal_addr] on the same edge.
//   pal_we and pal_commit may be asserted in the same cycle; the write is included in that commit.
// - Commit FSM, 2 states:
//   - IDLE -> PEND on pal_commit; pal_pending = 1 in PEND.
//   - PEND -> IDLE on a vsync_in rising edge (detected against the S0 copy). On that edge all
//     2**COLR_BITS entries copy shadow -> active in one cycle.
//   - pal_commit while in PEND: ignored, stays PEND.
//   - Commit at the same cycle as the vsync rise: stays PEND until the next vsync rise.
//   - pal_we during the copy cycle: the write lands in shadow only; active gets the pre-write value.
// - Active palette changes only on the copy cycle. Reads in S2 during the copy cycle return
//   the old value.
// - Arithmetic: no wrap concerns. All indices are unsigned COLR_BITS; NUM_SPR=1 must elaborate.
//
// STRUCTURE
// - Shared package gfx_pkg:
//   - typedef rgb_t (3*CHAN_BITS packed struct r,g,b)
//   - typedef colr_idx_t
//   - localparam COMP_LAT = 3
// - Sub-module sprite_palette: shadow and active register arrays, commit FSM, registered read port.
//   The top level holds the sync delay line and the priority select.
//
// TESTING
// - T1 reset: hold rst_n=0 for 2 cycles with de_in=1 -> rgb=0, de_out=0, pal_pending=0.
// - T2 priority: sprite0 pix=3, sprite2 pix=5, both drawing; palette[3]=0x112233, de_in=1
//   -> rgb=0x112233 exactly 3 cycles later.
// - T3 transparency: sprite0 pix=0 (TRANSP), sprite1 pix=7, bg_idx=9; palette[7]=0xFF0000
//   -> 0xFF0000. Drop all drawing -> palette[9].
// - T4 alignment: strobe spr_drawing one cycle before spr_pix -> no one-pixel fringe at either
//   sprite edge; hsync_out edges exactly LAT after hsync_in.
// - T5 commit: write shadow[4]=0x00FF00, pulse pal_commit mid-frame -> rgb for index 4 unchanged
//   and pal_pending=1 until the vsync_in rise; new colour from the next frame; pal_pending
//   drops on the copy cycle.
// - T6 blanking: de_in=0 with opaque sprites -> rgb=0. Also: pal_commit on the same cycle as
//   the vsync rise -> copy deferred one frame.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared types and constants for the sprite compositor slice.
package gfx_pkg;

    // Latency from the *_in/spr_drawing inputs to the compositor outputs.
    localparam int COMP_LAT      = 3;
    localparam int COLR_BITS_DEF = 4;
    localparam int CHAN_BITS_DEF = 8;

    typedef logic [COLR_BITS_DEF-1:0] colr_idx_t;

    typedef struct packed {
        logic [CHAN_BITS_DEF-1:0] r;
        logic [CHAN_BITS_DEF-1:0] g;
        logic [CHAN_BITS_DEF-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    typedef enum logic {
        PAL_IDLE = 1'b0,
        PAL_PEND = 1'b1
    } pal_state_e;

endpackage

// File: rtl/sprite_palette.sv
// Double-buffered colour palette: shadow array written by the host, active
// array read by the pixel pipeline, copied in one cycle at the vsync rise
// that follows a commit request.
module sprite_palette
    import gfx_pkg::*;
#(
    parameter int COLR_BITS = 4,
    parameter int CHAN_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_i,
    input  logic [COLR_BITS-1:0]   waddr_i,
    input  logic [3*CHAN_BITS-1:0] wdata_i,
    input  logic                   commit_i,
    input  logic                   vsync_rise_i,
    input  logic [COLR_BITS-1:0]   raddr_i,
    output logic [3*CHAN_BITS-1:0] rdata_o,
    output logic                   pending_o
);

    localparam int unsigned DEPTH = 2**COLR_BITS;

    logic [3*CHAN_BITS-1:0] shadow_q [DEPTH];
    logic [3*CHAN_BITS-1:0] active_q [DEPTH];
    logic [3*CHAN_BITS-1:0] rdata_q;
    pal_state_e             state_q;
    pal_state_e             state_d;
    logic                   copy;

    // Commit state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= PAL_IDLE;
        else        state_q <= state_d;
    end

    // Commit next-state: a request waits for the next vsync rise; a request
    // arriving on that rise itself is only registered, not serviced.
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        case (state_q)
            PAL_IDLE: if (commit_i) state_d = PAL_PEND;
            PAL_PEND: begin
                if (vsync_rise_i) begin
                    copy    = 1'b1;
                    state_d = PAL_IDLE;
                end
            end
            default: state_d = PAL_IDLE;
        endcase
    end

    // Host writes always land in the shadow copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
        end else if (we_i) begin
            shadow_q[waddr_i] <= wdata_i;
        end
    end

    // Whole-palette copy; a same-cycle shadow write is not seen by active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) active_q[i] <= '0;
        end else if (copy) begin
            for (int unsigned i = 0; i < DEPTH; i++) active_q[i] <= shadow_q[i];
        end
    end

    // Registered read port; returns the pre-copy value on the copy cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= active_q[raddr_i];
    end

    assign rdata_o   = rdata_q;
    assign pending_o = (state_q == PAL_PEND);

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: priority select of the lowest-numbered opaque sprite
// (background otherwise), palette lookup, and matching sync delay line.
module sprite_compositor
    import gfx_pkg::*;
#(
    parameter int NUM_SPR   = 4,
    parameter int COLR_BITS = 4,
    parameter int CHAN_BITS = 8,
    parameter int TRANSP    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SPR*COLR_BITS-1:0]   spr_pix,
    input  logic [NUM_SPR-1:0]             spr_drawing,
    input  logic [COLR_BITS-1:0]           bg_idx,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic                           de_in,
    input  logic                           pal_we,
    input  logic [COLR_BITS-1:0]           pal_addr,
    input  logic [3*CHAN_BITS-1:0]         pal_data,
    input  logic                           pal_commit,
    output logic                           pal_pending,
    output logic [3*CHAN_BITS-1:0]         rgb,
    output logic                           hsync_out,
    output logic                           vsync_out,
    output logic                           de_out
);

    localparam logic [COLR_BITS-1:0] TRANSP_IDX = COLR_BITS'(TRANSP);

    logic [NUM_SPR-1:0]     drawing_q;
    logic [COLR_BITS-1:0]   bg_q;
    logic [COLR_BITS-1:0]   sel_idx;
    sync_t                  sync_q [COMP_LAT];
    logic [3*CHAN_BITS-1:0] pal_rd;
    logic [3*CHAN_BITS-1:0] rgb_q;
    logic                   vsync_rise;

    // S0: strobes lead the pixel indices by a cycle; registering them aligns
    // drawing and background with spr_pix.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drawing_q <= '0;
            bg_q      <= '0;
        end else begin
            drawing_q <= spr_drawing;
            bg_q      <= bg_idx;
        end
    end

    // Sync delay line, one entry per pipeline stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < COMP_LAT; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {hsync_in, vsync_in, de_in};
            for (int unsigned i = 1; i < COMP_LAT; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign vsync_rise = vsync_in & ~sync_q[0].vs;

    // S1: lowest index opaque sprite wins; background is never transparent.
    always_comb begin
        logic found;
        sel_idx = bg_q;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (!found && drawing_q[i] &&
                spr_pix[i*COLR_BITS +: COLR_BITS] != TRANSP_IDX) begin
                sel_idx = spr_pix[i*COLR_BITS +: COLR_BITS];
                found   = 1'b1;
            end
        end
    end

    // S2: palette lookup (registered inside the palette).
    sprite_palette #(
        .COLR_BITS (COLR_BITS),
        .CHAN_BITS (CHAN_BITS)
    ) u_palette (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_i         (pal_we),
        .waddr_i      (pal_addr),
        .wdata_i      (pal_data),
        .commit_i     (pal_commit),
        .vsync_rise_i (vsync_rise),
        .raddr_i      (sel_idx),
        .rdata_o      (pal_rd),
        .pending_o    (pal_pending)
    );

    // S3: blank colour outside the display area.
    always_ff @(posedge clk) begin
        if (!rst_n) rgb_q <= '0;
        else        rgb_q <= sync_q[COMP_LAT-2].de ? pal_rd : '0;
    end

    assign rgb       = rgb_q;
    assign hsync_out = sync_q[COMP_LAT-1].hs;
    assign vsync_out = sync_q[COMP_LAT-1].vs;
    assign de_out    = sync_q[COMP_LAT-1].de;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios with literal
// expectations plus randomized traffic against a cycle-history model.
module tb_sprite_compositor;
    import gfx_pkg::*;

    localparam int NS   = 4;
    localparam int CB   = 4;
    localparam int CH   = 8;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*CB-1:0]  spr_pix;
    logic [NS-1:0]     spr_drawing;
    colr_idx_t         bg_idx;
    logic              hsync_in, vsync_in, de_in;
    logic              pal_we;
    logic [CB-1:0]     pal_addr;
    logic [3*CH-1:0]   pal_data;
    logic              pal_commit;
    logic              pal_pending;
    logic [3*CH-1:0]   rgb;
    logic              hsync_out, vsync_out, de_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model history, one entry per clock edge
    bit [NS-1:0] h_drw [MAXC];
    bit [CB-1:0] h_bg  [MAXC];
    bit          h_hs  [MAXC];
    bit          h_vs  [MAXC];
    bit          h_de  [MAXC];
    bit          h_rst [MAXC];
    bit [23:0]   h_pr  [MAXC];
    bit [23:0]   m_active [16];
    bit [23:0]   m_shadow [16];
    bit          m_pend;
    bit          m_prev_vs;
    int          kc = 2;

    logic [23:0] exp_rgb;
    logic        exp_hs, exp_vs, exp_de, exp_pend;

    sprite_compositor #(
        .NUM_SPR   (NS),
        .COLR_BITS (CB),
        .CHAN_BITS (CH),
        .TRANSP    (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spr_pix     (spr_pix),
        .spr_drawing (spr_drawing),
        .bg_idx      (bg_idx),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .de_in       (de_in),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
        .pal_commit  (pal_commit),
        .pal_pending (pal_pending),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .de_out      (de_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference: output after edge n is the pixel whose strobes were sampled
    // at edge n-2, with its indices one edge later, looked up in the palette
    // as it stood before edge n-1.
    task automatic model_edge();
        int       k;
        bit [3:0] sel, p;
        bit       found, rise;
        k = kc;
        if (k >= MAXC) begin
            $display("FAIL history_bound: cycle %0d reached limit %0d", k, MAXC);
            $fatal(1, "history overflow");
        end
        h_rst[k] = !rst_n;
        if (!rst_n) begin
            h_drw[k] = '0; h_bg[k] = '0; h_hs[k] = 0; h_vs[k] = 0; h_de[k] = 0; h_pr[k] = '0;
        end else begin
            h_drw[k] = spr_drawing; h_bg[k] = bg_idx;
            h_hs[k] = hsync_in; h_vs[k] = vsync_in; h_de[k] = de_in;
            sel   = h_bg[k-1];
            found = 0;
            for (int i = 0; i < NS; i++) begin
                p = spr_pix[i*CB +: CB];
                if (!found && h_drw[k-1][i] && p != 4'd0) begin
                    sel   = p;
                    found = 1;
                end
            end
            h_pr[k] = m_active[sel];
        end
        if (h_rst[k] || h_rst[k-1]) begin
            exp_rgb = '0; exp_hs = 0; exp_vs = 0; exp_de = 0;
        end else begin
            exp_hs  = h_hs[k-2];
            exp_vs  = h_vs[k-2];
            exp_de  = h_de[k-2];
            exp_rgb = h_de[k-2] ? h_pr[k-1] : 24'h0;
        end
        if (!rst_n) begin
            for (int a = 0; a < 16; a++) begin
                m_active[a] = '0;
                m_shadow[a] = '0;
            end
            m_pend    = 0;
            m_prev_vs = 0;
        end else begin
            rise = vsync_in && !m_prev_vs;
            if (m_pend && rise) begin
                m_active = m_shadow;
                m_pend   = 0;
            end else if (!m_pend && pal_commit) begin
                m_pend = 1;
            end
            if (pal_we) m_shadow[pal_addr] = pal_data;
            m_prev_vs = vsync_in;
        end
        exp_pend = m_pend;
        kc++;
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rgb",         rgb,         exp_rgb);
            check("hsync_out",   hsync_out,   exp_hs);
            check("vsync_out",   vsync_out,   exp_vs);
            check("de_out",      de_out,      exp_de);
            check("pal_pending", pal_pending, exp_pend);
        end
    end

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        spr_pix = '0; spr_drawing = '0; bg_idx = '0;
        hsync_in = 0; vsync_in = 0; de_in = 0;
        pal_we = 0; pal_addr = '0; pal_data = '0; pal_commit = 0;
    endtask

    function automatic logic [23:0] pal_init(input int a);
        logic [3:0] n;
        n = 4'(a);
        case (a)
            3:       return 24'h112233;
            7:       return 24'hFF0000;
            9:       return 24'h0000AA;
            default: return {n, n, n, n, n, n};
        endcase
    endfunction

    initial begin
        rgb_t lit;
        logic [15:0] rp;
        for (int i = 0; i < 2; i++) begin
            h_rst[i] = 1; h_drw[i] = '0; h_bg[i] = '0;
            h_hs[i] = 0; h_vs[i] = 0; h_de[i] = 0; h_pr[i] = '0;
        end
        idle();

        // T1 reset with de_in held high
        rst_n = 0; de_in = 1; chk_en = 1;
        tick(); tick();
        check("T1 rgb", rgb, 24'h0);
        check("T1 de_out", de_out, 1'b0);
        check("T1 pal_pending", pal_pending, 1'b0);

        // Palette load; last write shares its cycle with the commit
        rst_n = 1; idle();
        for (int a = 0; a < 16; a++) begin
            pal_we = 1; pal_addr = 4'(a); pal_data = pal_init(a);
            pal_commit = (a == 15);
            tick();
        end
        idle(); tick();
        check("load pending", pal_pending, 1'b1);
        vsync_in = 1; tick();
        check("load copy pending", pal_pending, 1'b0);
        idle(); tick(); tick(); tick();

        // T2 priority: sprite0 idx 3 beats sprite2 idx 5
        spr_drawing = 4'b0101; de_in = 1; bg_idx = 4'd1; tick();
        spr_drawing = '0; de_in = 0; bg_idx = '0; spr_pix = 16'h0503; tick();
        spr_pix = '0; tick();
        lit = '{r: 8'h11, g: 8'h22, b: 8'h33};
        check("T2 priority", rgb, lit);

        // T3 transparency then background fallback
        spr_drawing = 4'b0011; de_in = 1; bg_idx = 4'd9; tick();
        spr_drawing = '0; de_in = 0; bg_idx = '0; spr_pix = 16'h0070; tick();
        spr_pix = '0; tick();
        check("T3 transparent skip", rgb, 24'hFF0000);
        de_in = 1; bg_idx = 4'd9; tick();
        de_in = 0; bg_idx = '0; spr_pix = 16'h0070; tick();
        spr_pix = '0; tick();
        check("T3 background", rgb, 24'h0000AA);

        // T4 sync latency and a sprite span with leading strobe
        hsync_in = 1; tick(); tick();
        check("T4 hsync early", hsync_out, 1'b0);
        tick();
        check("T4 hsync rise", hsync_out, 1'b1);
        hsync_in = 0; tick(); tick();
        check("T4 hsync hold", hsync_out, 1'b1);
        tick();
        check("T4 hsync fall", hsync_out, 1'b0);
        for (int c = 0; c < 12; c++) begin
            spr_drawing = (c >= 2 && c < 8) ? 4'b0010 : 4'b0000;
            spr_pix = {8'h00, ((c >= 3 && c < 9) ? 4'h7 : 4'hC), 4'h0};
            de_in = 1; bg_idx = 4'd1;
            tick();
        end
        idle(); tick(); tick(); tick();

        // T5 mid-frame commit waits for vsync
        pal_we = 1; pal_addr = 4'd4; pal_data = 24'h00FF00; tick();
        pal_we = 0; pal_commit = 1; tick();
        pal_commit = 0; de_in = 1; bg_idx = 4'd4;
        repeat (5) tick();
        check("T5 old colour", rgb, 24'h444444);
        check("T5 pending", pal_pending, 1'b1);
        vsync_in = 1; tick();
        check("T5 pending drop", pal_pending, 1'b0);
        tick(); tick(); tick();
        check("T5 new colour", rgb, 24'h00FF00);
        vsync_in = 0; tick(); tick();

        // T6 blanking and commit coinciding with the vsync rise
        de_in = 0; spr_drawing = 4'b1111; spr_pix = 16'h3333;
        repeat (4) tick();
        check("T6 blank", rgb, 24'h0);
        idle(); tick();
        vsync_in = 1; pal_commit = 1; pal_we = 1; pal_addr = 4'd4; pal_data = 24'hABCDEF; tick();
        check("T6 deferred pending", pal_pending, 1'b1);
        pal_commit = 0; pal_we = 0; de_in = 1; bg_idx = 4'd4;
        tick(); tick(); tick();
        check("T6 not yet copied", rgb, 24'h00FF00);
        vsync_in = 0; tick(); tick();
        vsync_in = 1; tick();
        check("T6 copy pending", pal_pending, 1'b0);
        tick(); tick(); tick();
        check("T6 copied colour", rgb, 24'hABCDEF);
        idle(); tick();

        // Randomized traffic with a mid-run reset
        for (int c = 0; c < 2500; c++) begin
            rst_n = !(c == 1200 || c == 1201);
            rp = 16'($urandom());
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 9) < 3) rp[i*CB +: CB] = 4'h0;
            spr_pix     = rp;
            spr_drawing = 4'($urandom());
            bg_idx      = 4'($urandom());
            hsync_in    = (c % 23) < 3;
            vsync_in    = (c % 97) < 4;
            de_in       = ((c % 23) >= 5) && ($urandom_range(0, 9) != 0);
            pal_we      = $urandom_range(0, 3) == 0;
            pal_addr    = 4'($urandom());
            pal_data    = 24'($urandom());
            pal_commit  = $urandom_range(0, 24) == 0;
            tick();
        end
        rst_n = 1; idle(); tick(); tick(); tick();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
